// File: rtl/ram_arbiter.sv
// Two-requester arbiter/sequencer in front of a single registered-read RAM.
// Define RAM_ARB_FIXED_PRI_EN for fixed priority (requester 0 first); default is round-robin.
module ram_arbiter #(
  parameter int BYTE_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [BYTE_W-1:0] wdata0,
  output logic              ack0,
  output logic [BYTE_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [BYTE_W-1:0] wdata1,
  output logic              ack1,
  output logic [BYTE_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [BYTE_W-1:0] ram_wdata,
  output logic              ram_r_e,
  output logic              ram_w_e,
  input  logic [BYTE_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

  state_t state, state_nx;
  logic   owner;
  logic   elig0, elig1;
  logic   grant_vld, grant_sel;
  logic   sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [BYTE_W-1:0] sel_wdata;

`ifndef RAM_ARB_FIXED_PRI_EN
  logic   last_grant;
`endif

  // A requester whose ack is high this cycle still shows req; mask it out.
  always_comb begin
    elig0     = req0 & ~ack0;
    elig1     = req1 & ~ack1;
    grant_vld = elig0 | elig1;
`ifdef RAM_ARB_FIXED_PRI_EN
    grant_sel = ~elig0;
`else
    grant_sel = (elig0 & elig1) ? ~last_grant : elig1;
`endif
    sel_we    = grant_sel ? we1    : we0;
    sel_addr  = grant_sel ? addr1  : addr0;
    sel_wdata = grant_sel ? wdata1 : wdata0;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_vld) state_nx = ISSUE;
      ISSUE:   state_nx = ram_w_e ? IDLE : RDWAIT;
      RDWAIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // ram_w_e is still high during ISSUE, so it doubles as the transaction type.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= 1'b0;
`ifndef RAM_ARB_FIXED_PRI_EN
      last_grant <= 1'b1;
`endif
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_r_e   <= 1'b0;
      ram_w_e   <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            owner      <= grant_sel;
`ifndef RAM_ARB_FIXED_PRI_EN
            last_grant <= grant_sel;
`endif
            ram_addr   <= sel_addr;
            ram_wdata  <= sel_wdata;
            ram_w_e    <= sel_we;
            ram_r_e    <= ~sel_we;
          end
        end
        ISSUE: begin
          ram_r_e <= 1'b0;
          ram_w_e <= 1'b0;
          if (ram_w_e) begin
            if (owner) ack1 <= 1'b1;
            else       ack0 <= 1'b1;
          end
        end
        RDWAIT: begin
          if (owner) begin
            rdata1 <= ram_rdata;
            ack1   <= 1'b1;
          end else begin
            rdata0 <= ram_rdata;
            ack0   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural registered-read RAM attached.
module tb_ram_arbiter;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] rq  = 2'b00;
  logic [1:0] rwe = 2'b00;
  logic [7:0] raddr [2];
  logic [7:0] rwd   [2];
  logic       ack0, ack1;
  logic [7:0] rdata0, rdata1;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic       ram_r_e, ram_w_e;

  logic [1:0] ack;
  logic [7:0] rdv [2];
  assign ack    = {ack1, ack0};
  assign rdv[0] = rdata0;
  assign rdv[1] = rdata1;

  ram_arbiter #(.BYTE_W(8), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0(rq[0]), .we0(rwe[0]), .addr0(raddr[0]), .wdata0(rwd[0]), .ack0(ack0), .rdata0(rdata0),
    .req1(rq[1]), .we1(rwe[1]), .addr1(raddr[1]), .wdata1(rwd[1]), .ack1(ack1), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_r_e(ram_r_e), .ram_w_e(ram_w_e),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural simple_ram: registered read, drives 0 when not reading.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (ram_w_e) mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_r_e ? mem[ram_addr] : 8'h00;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  cmd_t       cq   [2][$];
  logic [7:0] expq [2][$];
  logic [7:0] mdl  [256];
  logic [7:0] last_rd [2];
  logic [1:0] busy = 2'b00;
  int         t_load [2];
  int         ack_cyc [2];
  int         ack_cnt [2];
  int         order [$];
  int         we_cnt = 0, re_cnt = 0, we_cyc = 0, re_cyc = 0;
  logic [7:0] we_addr, we_data;
  logic [3:0] prev_pulse = 4'b0;

  // Requesters: present a command, hold it until ack, then load the next or drop req.
  initial begin
    raddr[0] = 8'h00; raddr[1] = 8'h00; rwd[0] = 8'h00; rwd[1] = 8'h00;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          rq[i]   = 1'b0;
          busy[i] = 1'b0;
        end else if (busy[i]) begin
          if (ack[i]) busy[i] = 1'b0;
        end else if (cq[i].size() > 0) begin
          cmd_t c;
          c         = cq[i].pop_front();
          rq[i]     = 1'b1;
          rwe[i]    = c.we;
          raddr[i]  = c.addr;
          rwd[i]    = c.data;
          busy[i]   = 1'b1;
          t_load[i] = cyc;
        end else begin
          rq[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: protocol invariants and scoreboard pops on every ack.
  always @(negedge clk) begin
    if (rst) begin
      prev_pulse <= 4'b0;
    end else begin
      chk("ack_exclusive", 64'(ack0 & ack1), 0);
      chk("en_exclusive", 64'(ram_r_e & ram_w_e), 0);
      chk("single_cycle_pulse", 64'(prev_pulse & {ack1, ack0, ram_r_e, ram_w_e}), 0);
      prev_pulse <= {ack1, ack0, ram_r_e, ram_w_e};
      if (ram_w_e) begin
        we_cnt++; we_cyc = cyc; we_addr = ram_addr; we_data = ram_wdata;
      end
      if (ram_r_e) begin
        re_cnt++; re_cyc = cyc;
      end
      for (int i = 0; i < 2; i++) begin
        if (ack[i]) begin
          ack_cnt[i]++;
          ack_cyc[i] = cyc;
          order.push_back(i);
          chk("ack_expected", 64'(expq[i].size() != 0), 1);
          if (expq[i].size() != 0)
            chk($sformatf("rdata%0d", i), 64'(rdv[i]), 64'(expq[i].pop_front()));
        end
      end
    end
  end

  task automatic enq(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
    cmd_t c;
    c.we = w; c.addr = a; c.data = d;
    if (w) mdl[a] = d;
    else   last_rd[i] = mdl[a];
    expq[i].push_back(last_rd[i]);
    cq[i].push_back(c);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (((cq[0].size() + cq[1].size() + expq[0].size() + expq[1].size()) != 0 || busy != 2'b00)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_budget", 64'(n < budget), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_sb();
    for (int i = 0; i < 2; i++) begin
      cq[i].delete();
      expq[i].delete();
      last_rd[i] = 8'h00;
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({ack0, ack1, rdata0, rdata1, ram_addr, ram_wdata, ram_r_e, ram_w_e});
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_sb();
    repeat (2) @(negedge clk);
    chk("reset_outputs", all_outs(), 0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  int base, idx, b_we, b_re, b_ack;

  initial begin
    clear_sb();
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", all_outs(), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single write by requester 0
    b_we = we_cnt;
    enq(0, 1'b1, 8'h12, 8'hA5);
    drain(50);
    chk("wr_we_count", 64'(we_cnt - b_we), 1);
    chk("wr_we_cycle", 64'(we_cyc), 64'(t_load[0] + 1));
    chk("wr_ram_addr", 64'(we_addr), 64'h12);
    chk("wr_ram_wdata", 64'(we_data), 64'hA5);
    chk("wr_ack_cycle", 64'(ack_cyc[0]), 64'(t_load[0] + 2));
    chk("wr_rdata0_kept", 64'(rdata0), 0);

    // Read back by requester 1
    b_re = re_cnt;
    enq(1, 1'b0, 8'h12, 8'h00);
    drain(50);
    chk("rd_re_count", 64'(re_cnt - b_re), 1);
    chk("rd_re_cycle", 64'(re_cyc), 64'(t_load[1] + 1));
    chk("rd_ack_cycle", 64'(ack_cyc[1]), 64'(t_load[1] + 3));
    repeat (3) @(negedge clk);
    chk("rd_rdata1_held", 64'(rdata1), 64'hA5);

    // Max address: write by 1, read by 0
    enq(1, 1'b1, 8'hFF, 8'h3C);
    drain(50);
    enq(0, 1'b0, 8'hFF, 8'h00);
    drain(50);
    chk("maxaddr_rdata0", 64'(rdata0), 64'h3C);
    chk("maxaddr_rdata1_kept", 64'(rdata1), 64'hA5);

    // Contested reads straight after reset alternate starting with 0
    do_reset();
    base = order.size();
    enq(0, 1'b0, 8'h12, 8'h00); enq(0, 1'b0, 8'hFF, 8'h00);
    enq(1, 1'b0, 8'hFF, 8'h00); enq(1, 1'b0, 8'h12, 8'h00);
    drain(100);
    chk("rr_ack_count", 64'(order.size() - base), 4);
    for (int k = 0; k < 4; k++)
      if (base + k < order.size()) chk($sformatf("rr_order%0d", k), 64'(order[base + k]), 64'(k % 2));

    // Requester 1 waits at most one transaction behind a continuous requester 0
    base = order.size();
    for (int k = 0; k < 6; k++) enq(0, 1'b1, 8'(8'h20 + k), 8'(k + 1));
    enq(1, 1'b0, 8'h12, 8'h00);
    drain(200);
    idx = 99;
    for (int k = base; k < order.size(); k++)
      if (order[k] == 1 && idx == 99) idx = k - base;
    chk("fair_wait", 64'(idx <= 1), 1);

    // Contested grant after requester 0 was served last
    enq(0, 1'b1, 8'h30, 8'h11);
    drain(50);
    base = order.size();
    enq(0, 1'b1, 8'h31, 8'h22);
    enq(1, 1'b0, 8'h30, 8'h00);
    drain(50);
`ifdef RAM_ARB_FIXED_PRI_EN
    chk("contest_winner", 64'(order[base]), 0);
`else
    chk("contest_winner", 64'(order[base]), 1);
`endif

    // Reset asserted during RDWAIT of a read
    b_ack = ack_cnt[0];
    b_re  = re_cnt;
    enq(0, 1'b0, 8'h12, 8'h00);
    idx = 0;
    while (re_cnt == b_re && idx < 20) begin
      @(negedge clk);
      idx++;
    end
    chk("rdwait_reached", 64'(idx < 20), 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", all_outs(), 0);
    clear_sb();
    repeat (3) @(negedge clk);
    chk("no_ack_after_abort", 64'(ack_cnt[0] - b_ack), 0);
    rst = 1'b0;
    @(negedge clk);
    base = order.size();
    enq(0, 1'b0, 8'hFF, 8'h00);
    enq(1, 1'b0, 8'h12, 8'h00);
    drain(50);
    chk("post_reset_winner", 64'(order[base]), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
